aes_round_ctrl: RTL

Iterative AES encryption round sequencer. It accepts one plaintext block, performs the initial AddRoundKey, then drives a shared combinational round datapath (SubBytes -> ShiftRows -> optional MixColumns -> AddRoundKey) once per cycle for NUM_ROUNDS rounds. It indexes the external round-key store and returns the ciphertext over a valid/ready handshake. It sits between the host-side block interface and the round datapath / key-schedule RAM in the AES chip.

---
 rtl/aes_round_ctrl.sv | 98 +++++++++
 1 files changed

// File: rtl/aes_round_ctrl.sv
// Iterative AES encryption round sequencer: initial AddRoundKey, then NUM_ROUNDS
// passes through an external combinational round datapath, result via valid/ready.
module aes_round_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int RK_IDX_W   = 4
) (
   input  logic                clk_i,
   input  logic                reset_n_i,
   input  logic                v_i,
   output logic                ready_o,
   input  logic [127:0]        plaintext_i,
   output logic [RK_IDX_W-1:0] rk_idx_o,
   input  logic [127:0]        rk_i,
   output logic [127:0]        dp_state_o,
   output logic                dp_final_o,
   input  logic [127:0]        dp_result_i,
   output logic                v_o,
   output logic [127:0]        ciphertext_o,
   input  logic                ready_i,
   output logic                busy_o,
   output logic [RK_IDX_W-1:0] round_o
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // Input side: v_i/ready_o (ready_o only in IDLE). Output side: v_o/ready_i, with
   // ciphertext_o held stable from v_o rising until the accepting edge.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_e;

   localparam logic [RK_IDX_W-1:0] LAST_RND = RK_IDX_W'(NUM_ROUNDS);
   localparam logic [RK_IDX_W-1:0] ONE_RND  = RK_IDX_W'(1);

   fsm_e                fsm_q, fsm_d;
   logic [RK_IDX_W-1:0] round_q, round_d;
   logic [127:0]        state_q, state_d;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         fsm_q   <= IDLE;
         round_q <= '0;
         state_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         round_q <= round_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      round_d = round_q;
      state_d = state_q;
      case (fsm_q)
         IDLE: begin
            round_d = '0;
            if (v_i) begin
               // rk_idx_o is 0 here, so rk_i is the whitening key
               state_d = plaintext_i ^ rk_i;
               round_d = ONE_RND;
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = dp_result_i;
            // Equality stop keeps the counter from wrapping when NUM_ROUNDS = 2**RK_IDX_W-1
            if (round_q == LAST_RND) begin
               fsm_d = DONE;
            end else begin
               round_d = round_q + ONE_RND;
            end
         end
         DONE: begin
            if (ready_i) begin
               fsm_d   = IDLE;
               round_d = '0;
            end
         end
         default: begin
            fsm_d   = IDLE;
            round_d = '0;
         end
      endcase
   end

   assign ready_o      = (fsm_q == IDLE);
   assign v_o          = (fsm_q == DONE);
   assign busy_o       = (fsm_q == ROUND);
   assign rk_idx_o     = round_q;
   assign round_o      = round_q;
   assign dp_state_o   = state_q;
   assign ciphertext_o = state_q;
   assign dp_final_o   = (fsm_q == ROUND) && (round_q == LAST_RND);

endmodule
